// File: rtl/uart_fifo_io.sv
// 8N1 UART behind a two-port CPU I/O window with TX and RX FIFOs.
// Optional interrupt enables and irq output are built when UART_FIFO_IO_IRQ_EN is defined.

module uart_fifo_io_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int PW = DEPTH_LOG2 + 1;

  logic [7:0]    mem_q [2**DEPTH_LOG2];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (flush_i) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (push_i) wp_d = wp_q + 1'b1;
      if (pop_i)  rp_d = rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q[PW-2:0]] <= din_i;
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign head_o  = mem_q[rp_q[PW-2:0]];
  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[PW-1] != rp_q[PW-1]) && (wp_q[PW-2:0] == rp_q[PW-2:0]);
endmodule

module uart_fifo_io #(
  parameter int         CLK_HZ     = 50_000_000,
  parameter int         BAUD       = 115_200,
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] BASE       = 8'hE8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);
  localparam int         DIV_RAW = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int         DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int         DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [7:0] BASE_P1 = BASE + 8'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} st_e;

  logic [DIV_W-1:0] div_q;
  logic             tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= tick ? '0 : div_q + 1'b1;
  end
  assign tick = (div_q == DIV_W'(DIV - 1));

  logic sel_data, sel_ctl, flush;
  assign sel_data = (addr == BASE);
  assign sel_ctl  = (addr == BASE_P1);
  assign flush    = wr & sel_ctl & din[7];

  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_head;

  st_e        tx_st_q;
  logic [3:0] tx_cnt_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_sh_q;
  logic       tx_q;

  assign tx_push = wr & sel_data & ~tx_full;
  assign tx_pop  = tick & ~tx_empty &
                   ((tx_st_q == ST_IDLE) | ((tx_st_q == ST_STOP) & (tx_cnt_q == 4'd15)));

  uart_fifo_io_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_txf (
    .clk(clk), .rst(rst), .flush_i(flush), .push_i(tx_push), .pop_i(tx_pop),
    .din_i(din), .head_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
  );

  // Transmitter: a new frame starts straight from STOP when more data is queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q  <= ST_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else if (tick) begin
      case (tx_st_q)
        ST_IDLE: begin
          if (!tx_empty) begin
            tx_st_q  <= ST_START;
            tx_q     <= 1'b0;
            tx_sh_q  <= tx_head;
            tx_cnt_q <= '0;
          end
        end
        ST_START: begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
          if (tx_cnt_q == 4'd15) begin
            tx_st_q  <= ST_DATA;
            tx_q     <= tx_sh_q[0];
            tx_bit_q <= '0;
          end
        end
        ST_DATA: begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
          if (tx_cnt_q == 4'd15) begin
            if (tx_bit_q == 3'd7) begin
              tx_st_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              tx_q     <= tx_sh_q[1];
            end
          end
        end
        default: begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
          if (tx_cnt_q == 4'd15) begin
            if (!tx_empty) begin
              tx_st_q <= ST_START;
              tx_q    <= 1'b0;
              tx_sh_q <= tx_head;
            end else begin
              tx_st_q <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end
  assign tx = tx_q;

  logic rx_m_q, rx_s_q, rx_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_m_q    <= rx;
      rx_s_q    <= rx_m_q;
      rx_prev_q <= rx_s_q;
    end
  end

  st_e        rx_st_q;
  logic [3:0] rx_cnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_sh_q;
  logic       rx_vld_q, rx_ferr_q;

  // Receiver: START is checked mid-bit, then each later sample lands 16 ticks on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st_q   <= ST_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_st_q)
        ST_IDLE: begin
          if (rx_prev_q && !rx_s_q) begin
            rx_st_q  <= ST_START;
            rx_cnt_q <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
            if (rx_cnt_q == 4'd7) begin
              rx_cnt_q <= '0;
              rx_bit_q <= '0;
              rx_st_q  <= rx_s_q ? ST_IDLE : ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
            if (rx_cnt_q == 4'd15) begin
              rx_sh_q  <= {rx_s_q, rx_sh_q[7:1]};
              rx_bit_q <= rx_bit_q + 1'b1;
              if (rx_bit_q == 3'd7) rx_st_q <= ST_STOP;
            end
          end
        end
        default: begin
          if (tick) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
            if (rx_cnt_q == 4'd15) begin
              rx_st_q   <= ST_IDLE;
              rx_vld_q  <= rx_s_q;
              rx_ferr_q <= ~rx_s_q;
            end
          end
        end
      endcase
    end
  end

  assign rx_pop  = rd & sel_data & ~rx_empty;
  assign rx_push = rx_vld_q & (~rx_full | rx_pop);

  uart_fifo_io_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rxf (
    .clk(clk), .rst(rst), .flush_i(flush), .push_i(rx_push), .pop_i(rx_pop),
    .din_i(rx_sh_q), .head_o(rx_head), .empty_o(rx_empty), .full_o(rx_full)
  );

  logic txovr_q, txovr_d, ferr_q, ferr_d, rxovr_q, rxovr_d, sts_clr, txe;

  // Set events are ORed after the clear so they win in the same cycle.
  assign sts_clr = rd & sel_ctl;
  assign txovr_d = (txovr_q & ~sts_clr) | (wr & sel_data & tx_full);
  assign ferr_d  = (ferr_q  & ~sts_clr) | rx_ferr_q;
  assign rxovr_d = (rxovr_q & ~sts_clr) | (rx_vld_q & rx_full & ~rx_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txovr_q <= 1'b0;
      ferr_q  <= 1'b0;
      rxovr_q <= 1'b0;
    end else begin
      txovr_q <= txovr_d;
      ferr_q  <= ferr_d;
      rxovr_q <= rxovr_d;
    end
  end

  assign txe = tx_empty & (tx_st_q == ST_IDLE);

  logic [1:0] ie_bits;
`ifdef UART_FIFO_IO_IRQ_EN
  logic rxie_q, txie_q, irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxie_q <= 1'b0;
      txie_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr && sel_ctl) begin
        rxie_q <= din[0];
        txie_q <= din[1];
      end
      irq_q <= (rxie_q & ~rx_empty) | (txie_q & txe);
    end
  end
  assign ie_bits = {txie_q, rxie_q};
  assign irq     = irq_q;
`else
  assign ie_bits = 2'b00;
  assign irq     = 1'b0;
`endif

  always_comb begin
    dout = 8'h00;
    if (sel_data) begin
      if (!rx_empty) dout = rx_head;
    end else if (sel_ctl) begin
      dout = {ie_bits, txovr_q, ferr_q, rxovr_q, txe, ~tx_full, ~rx_empty};
    end
  end
endmodule

// File: tb/tb_uart_fifo_io.sv
// Scoreboard bench for uart_fifo_io at 16 clk per bit, 4-entry FIFOs.
// Irq behaviour is exercised according to whether UART_FIFO_IO_IRQ_EN is defined.

module tb_uart_fifo_io;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr, din, dout;
  logic       wr, rd, rx, tx, irq;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];

  uart_fifo_io #(.CLK_HZ(16_000_000), .BAUD(1_000_000), .DEPTH_LOG2(2), .BASE(8'hE8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .din(din),
    .dout(dout), .rx(rx), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_port(input logic [7:0] a, input logic [7:0] d);
    addr = a; din = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; addr = 8'h00;
  endtask

  task automatic rd_port(input logic [7:0] a, output logic [7:0] d);
    addr = a; rd = 1'b1;
    #1 d = dout;
    @(negedge clk);
    rd = 1'b0; addr = 8'h00;
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    addr = a;
    #1 d = dout;
  endtask

  task automatic chk_status(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    peek(8'hE9, d);
    chk_eq(tag, 32'(d), 32'(exp));
  endtask

  task automatic rx_read(input string tag);
    logic [7:0] d, e;
    rd_port(8'hE8, d);
    e = 8'h00;
    if (rxq.size() > 0) e = rxq.pop_front();
    chk_eq(tag, 32'(d), 32'(e));
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    if (stop && rxq.size() < 4) rxq.push_back(b);
  endtask

  task automatic tx_recv(input string tag, output int k);
    logic [7:0] b, e;
    k = 0;
    while (tx !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      chk_eq({tag, "_start_timeout"}, 32'(k), 32'(0));
    end else begin
      repeat (8) @(negedge clk);
      chk_eq({tag, "_startbit"}, 32'(tx), 32'(0));
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = tx;
      end
      repeat (16) @(negedge clk);
      chk_eq({tag, "_stopbit"}, 32'(tx), 32'(1));
      e = 8'hxx;
      if (txq.size() > 0) e = txq.pop_front();
      chk_eq({tag, "_byte"}, 32'(b), 32'(e));
    end
  endtask

  task automatic count_tx_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  int   mon_phase = 0;
  logic mon_arm = 1'b0;
  logic irq_at_rise, irq_after;

  always @(negedge clk) begin
    if (mon_arm) begin
      if (mon_phase == 1) begin
        irq_after <= irq;
        mon_phase <= 2;
      end else if (mon_phase == 0 && addr == 8'hE9 && dout[0]) begin
        irq_at_rise <= irq;
        mon_phase   <= 1;
      end
    end
  end

  initial begin
    int k, lows;
    logic [7:0] d;
    rst = 1'b1; addr = 8'h00; din = 8'h00; wr = 1'b0; rd = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("rst_tx", 32'(tx), 32'(1));
    chk_eq("rst_irq", 32'(irq), 32'(0));
    chk_status("rst_status", 8'h06);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single TX frame
    txq.push_back(8'h55);
    wr_port(8'hE8, 8'h55);
    tx_recv("tx55", k);
    chk_eq("tx55_latency_ok", 32'(k <= 2), 32'(1));
    chk_status("tx55_busy", 8'h02);
    repeat (12) @(negedge clk);
    chk_status("tx55_done", 8'h06);

    // single RX frame
    send_rx(8'hA3, 1'b1);
    chk_status("rxA3_rxne", 8'h07);
    rx_read("rxA3_data");
    chk_status("rxA3_after", 8'h06);

    // RX overflow
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    chk_status("rxovr_status", 8'h0F);
    for (int i = 0; i < 5; i++) rx_read("rxovr_read");
    rd_port(8'hE9, d);
    chk_eq("rxovr_clr_read", 32'(d), 32'(8'h0E));
    chk_status("rxovr_cleared", 8'h06);

    // framing error
    send_rx(8'h5A, 1'b0);
    chk_status("ferr_status", 8'h16);
    rd_port(8'hE9, d);
    chk_eq("ferr_clr_read", 32'(d), 32'(8'h16));
    chk_status("ferr_cleared", 8'h06);

    // reset in the middle of a TX data bit
    wr_port(8'hE8, 8'hF0);
    k = 0;
    while (tx !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    repeat (24) @(negedge clk);
    chk_eq("rstmid_tx_low", 32'(tx), 32'(0));
    #2 rst = 1'b1;
    #1 chk_eq("rstmid_tx_async", 32'(tx), 32'(1));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_status("rstmid_status", 8'h06);
    count_tx_low(300, lows);
    chk_eq("rstmid_quiet", 32'(lows), 32'(0));

    // TX overflow and back-to-back frames
    for (int i = 0; i < 6; i++) begin
      if (i < 5) txq.push_back(8'h11 + 8'(i));
      wr_port(8'hE8, 8'h11 + 8'(i));
    end
    chk_status("txovr_status", 8'h20);
    rd_port(8'hE9, d);
    chk_eq("txovr_clr_read", 32'(d), 32'(8'h20));
    chk_status("txovr_cleared", 8'h00);
    for (int i = 0; i < 5; i++) begin
      tx_recv("txb2b", k);
      chk_eq("txb2b_no_gap", 32'(i == 0 || k <= 9), 32'(1));
    end
    repeat (12) @(negedge clk);
    chk_status("txb2b_done", 8'h06);

    // flush: frame in flight completes, queued bytes vanish
    send_rx(8'h42, 1'b1);
    txq.push_back(8'hA1);
    wr_port(8'hE8, 8'hA1);
    wr_port(8'hE8, 8'hA2);
    wr_port(8'hE8, 8'hA3);
    wr_port(8'hE9, 8'h80);
    rxq.delete();
    chk_status("flush_rx_empty", 8'h02);
    tx_recv("flush", k);
    count_tx_low(200, lows);
    chk_eq("flush_quiet", 32'(lows), 32'(0));
    chk_status("flush_status", 8'h06);
    rx_read("flush_rd_empty");

`ifdef UART_FIFO_IO_IRQ_EN
    wr_port(8'hE9, 8'h01);
    chk_status("irq_rxie", 8'h46);
    addr = 8'hE9;
    mon_arm = 1'b1;
    send_rx(8'h7E, 1'b1);
    mon_arm = 1'b0;
    chk_eq("irq_rise_seen", 32'(mon_phase), 32'(2));
    chk_eq("irq_at_rxne", 32'(irq_at_rise), 32'(0));
    chk_eq("irq_one_clk", 32'(irq_after), 32'(1));
    rx_read("irq_data");
    chk_eq("irq_hold", 32'(irq), 32'(1));
    @(negedge clk);
    chk_eq("irq_clear", 32'(irq), 32'(0));
`else
    wr_port(8'hE9, 8'h03);
    chk_status("noirq_status", 8'h06);
    send_rx(8'h7E, 1'b1);
    chk_eq("noirq_irq", 32'(irq), 32'(0));
    chk_status("noirq_rxne", 8'h07);
    rx_read("noirq_data");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_fifo_io.md
UART_FIFO_IO -- requirements
Module: uart_fifo_io

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200: line rate.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4: each FIFO holds 2**DEPTH_LOG2 bytes, range 1..8.
REQ-004 SHALL have parameter BASE, default 8'hE8: data port at BASE, control/status port at BASE+1.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 addr  input  8  CPU I/O port address.
REQ-008 wr  input  1  one-clk write strobe, active-high.
REQ-009 rd  input  1  one-clk read strobe, active-high.
REQ-010 din  input  8  CPU write data.
REQ-011 dout  output  8  read data; combinational mux on addr.
REQ-012 rx  input  1  serial in, idle high, asynchronous to clk.
REQ-013 tx  output  1  serial out, idle high.
REQ-014 irq  output  1  level interrupt request, active-high.

Function
REQ-015 SHALL generate a 16x oversample tick every DIV clk, DIV = max(1, (CLK_HZ+8*BAUD)/(16*BAUD)), from a free-running counter.
REQ-016 Frame format SHALL be 8N1, LSB first; every bit lasts 16 ticks.
REQ-017 wr to BASE SHALL push din into the TX FIFO; when TX FIFO is full, the byte SHALL be dropped and TXOVR set.
REQ-018 TX FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START on the first tick with TX FIFO non-empty, popping the head; after STOP, it SHALL go directly to START if FIFO non-empty (no idle gap), otherwise to IDLE.
REQ-019 rx SHALL be double-flop synchronised before use.
REQ-020 RX FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START on a synchronised falling edge; at tick 8 of START, low->DATA, high->IDLE (glitch reject); DATA bits SHALL be sampled at tick 8 of each bit; STOP SHALL be sampled at tick 8, then return to IDLE.
REQ-021 Stop bit 1 SHALL push the byte into the RX FIFO; stop bit 0 SHALL set FERR and discard the byte.
REQ-022 A push into a full RX FIFO without a same-cycle pop SHALL drop the new byte and set RXOVR; a simultaneous push and pop on a full FIFO SHALL perform both.
REQ-023 A read of BASE SHALL return the RX FIFO head (FWFT); rd SHALL pop; read when empty SHALL return 8'h00 with no pop.
REQ-024 A read of BASE+1 SHALL return status {2'b00, TXOVR, FERR, RXOVR, TXE, TXNF, RXNE}; TXE = TX FIFO empty and TX FSM in IDLE.
REQ-025 rd of BASE+1 SHALL clear TXOVR, FERR and RXOVR; a set event in the same cycle SHALL win over the clear.
REQ-026 A write to BASE+1 with din[7]=1 SHALL flush both FIFOs; the frame in progress SHALL complete.
REQ-027 Any other addr SHALL produce dout = 8'h00 and ignore wr and rd.
REQ-028 FIFO pointers SHALL be DEPTH_LOG2+1 bits wide with wrap-around; full and empty are derived from the MSB comparison.

Reset
REQ-029 While rst=1, the block SHALL hold tx=1, irq=0, both FIFOs empty, both FSMs in IDLE, all sticky flags at 0, IRQ enables at 0, and the divider at 0; status SHALL read 8'h06.
REQ-030 rst asserted mid-frame SHALL abort the frame immediately and take effect on rst assertion, without waiting for a clk edge.

Configuration
REQ-031 Macro UART_FIFO_IO_IRQ_EN defined: a write to BASE+1 SHALL load din[0] into RXIE and din[1] into TXIE, and status bits [7:6] SHALL read {TXIE, RXIE}.
REQ-032 With UART_FIFO_IO_IRQ_EN defined, irq SHALL equal (RXIE & RXNE) | (TXIE & TXE), registered, with 1 clk latency.
REQ-033 Macro UART_FIFO_IO_IRQ_EN undefined: irq SHALL be constant 0, status[7:6] SHALL read 0, and din[1:0] writes SHALL be ignored.

Verification (CLK_HZ=16_000_000, BAUD=1_000_000, DEPTH_LOG2=2, so 16 clk per bit)
REQ-034 Write 0x55 to E8 -> tx goes low within 2 tick periods, then the bits 1,0,1,0,1,0,1,0 follow, then the stop bit, each 16 clk; status bit2 returns to 1 after STOP.
REQ-035 Drive an rx frame carrying 0xA3 -> RXNE=1 after the stop sample; read E8 returns 0xA3; status then reads 0x06.
REQ-036 Send 5 rx frames 0x01..0x05 without reading -> status=0x0F; reads return 0x01..0x04, then 0x00; status read clears RXOVR.
REQ-037 Send an rx frame with stop bit 0 -> RXNE stays 0 and FERR=1 (status 0x16); a second status read returns 0x06.
REQ-038 Assert rst during DATA of a TX frame -> tx=1 in the same cycle, status=0x06 after release, no further tx activity.
REQ-039 With UART_FIFO_IO_IRQ_EN defined: write 0x01 to E9, then receive 0x7E -> irq=1 one clk after RXNE rises; read E8 -> irq=0 one clk later.
